// File: rtl/upscale_link_pkg.sv
// Shared constants and types for the core-side outbound link arbiter.
package upscale_link_pkg;

  localparam int LINK_WIDTH   = 80;
  localparam int NUM_LINK_REQ = 4;

  typedef enum logic {IDLE, LOCK} arb_state_e;

  typedef enum logic [1:0] {PIX0, PIX1, STATUS, CFG_ECHO} link_req_e;

endpackage

// File: rtl/upscale_rr_pick.sv
// Rotating priority encoder: first set candidate at or after rr_ptr_i, wrapping to 0.
// Purely combinational; no backpressure.
module upscale_rr_pick #(
  parameter int  num_req_p = 4,
  localparam int IdxW      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0] cand_i,
  input  logic [IdxW-1:0]      rr_ptr_i,
  output logic                 found_o,
  output logic [IdxW-1:0]      idx_o
);

  int slot;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    slot    = 0;
    for (int i = 0; i < num_req_p; i++) begin
      slot = (int'(rr_ptr_i) + i) % num_req_p;
      if (!found_o && cand_i[slot]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(slot);
      end
    end
  end

endmodule

// File: rtl/upscale_link_arb.sv
// Packet-level round-robin arbiter onto the shared core-side link; 0-cycle beat latency.
// A winner holds the link until its last beat is taken; ready_i low holds the beat and withholds yumi.
module upscale_link_arb
  import upscale_link_pkg::*;
#(
  parameter int  num_req_p     = NUM_LINK_REQ,
  parameter int  width_p       = LINK_WIDTH,
  parameter int  stall_limit_p = 255,
  localparam int IdxW          = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           async_reset_n_i,
  input  logic [num_req_p-1:0]           en_mask_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [num_req_p*width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]           req_last_i,
  output logic [num_req_p-1:0]           req_yumi_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           ready_i,
  output logic [IdxW-1:0]                owner_o,
  output logic                           busy_o,
  output logic [15:0]                    pkt_cnt_o,
  output logic                           stall_err_o
);

  localparam int                StallW   = $clog2(stall_limit_p + 1);
  localparam logic [StallW-1:0] StallLim = StallW'(stall_limit_p);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;

  logic [num_req_p-1:0] cand;
  logic                 pick_found;
  logic [IdxW-1:0]      pick_idx;
  logic [IdxW-1:0]      sel_idx;
  logic [IdxW-1:0]      rr_next;
  logic                 sel_v;
  logic                 sel_last;
  logic                 accept;

  assign cand = req_v_i & en_mask_i;

  upscale_rr_pick #(.num_req_p(num_req_p)) u_pick (
    .cand_i   (cand),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  // While locked the enable mask is bypassed so a packet can always finish.
  assign sel_idx  = (state_q == LOCK) ? owner_q : pick_idx;
  assign sel_v    = (state_q == LOCK) ? req_v_i[owner_q] : pick_found;
  assign sel_last = req_last_i[sel_idx];
  assign rr_next  = (sel_idx == IdxW'(num_req_p - 1)) ? '0 : sel_idx + IdxW'(1);
  assign accept   = v_o & ready_i;

  // Outputs stay quiet while reset is held so a live requester cannot leak a grant.
  assign v_o         = async_reset_n_i & sel_v;
  assign data_o      = async_reset_n_i ? req_data_i[sel_idx*width_p +: width_p] : '0;
  assign req_yumi_o  = accept ? (num_req_p'(1) << sel_idx) : '0;
  assign owner_o     = !async_reset_n_i ? '0 :
                       (state_q == IDLE && pick_found) ? pick_idx : owner_q;
  assign busy_o      = (state_q == LOCK);
  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_err_o = stall_err_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;

    if (state_q == IDLE) begin
      stall_cnt_d = '0;
      if (accept) begin
        owner_d = pick_idx;
        if (sel_last) rr_ptr_d = rr_next;
        else          state_d  = LOCK;
      end
    end else begin
      if (req_v_i[owner_q])          stall_cnt_d = '0;
      else if (stall_cnt_q != StallLim) stall_cnt_d = stall_cnt_q + StallW'(1);
      if (stall_cnt_d == StallLim) stall_err_d = 1'b1;
      if (accept && sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next;
      end
    end

    if (accept && sel_last && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule

// File: tb/tb_upscale_link_arb.sv
// Randomized scoreboard bench for upscale_link_arb against a packet-level reference model.
module tb_upscale_link_arb;

  localparam int N = 4;
  localparam int W = 80;

  logic           clk_i = 1'b0;
  logic           async_reset_n_i;
  logic [N-1:0]   en_mask_i;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_i;
  logic [1:0]     owner_o;
  logic           busy_o;
  logic [15:0]    pkt_cnt_o;
  logic           stall_err_o;

  upscale_link_arb dut (
    .clk_i           (clk_i),
    .async_reset_n_i (async_reset_n_i),
    .en_mask_i       (en_mask_i),
    .req_v_i         (req_v_i),
    .req_data_i      (req_data_i),
    .req_last_i      (req_last_i),
    .req_yumi_o      (req_yumi_o),
    .v_o             (v_o),
    .data_o          (data_o),
    .ready_i         (ready_i),
    .owner_o         (owner_o),
    .busy_o          (busy_o),
    .pkt_cnt_o       (pkt_cnt_o),
    .stall_err_o     (stall_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         v;
    logic [W-1:0] dat;
    int           own;
    logic [N-1:0] yumi;
    logic         busy;
    int           pkt;
    logic         err;
  } stat_t;

  typedef struct {
    int           own;
    logic [W-1:0] dat;
  } beat_t;

  stat_t sq[$];
  beat_t bq[$];

  int checks = 0;
  int errors = 0;

  // Requester sources: remaining beats of current packet and the beat on offer.
  int           rem [N];
  logic [W-1:0] bt  [N];
  int           gen_max = 0;

  // Reference model state.
  bit m_lock;
  int m_owner, m_ptr, m_pkt, m_stall;
  bit m_err;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_beat();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic new_pkt(input int k, input int len);
    rem[k] = len;
    bt[k]  = rand_beat();
  endtask

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_pkt = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic model_eval();
    logic [N-1:0] cand;
    int    win, idx;
    bit    ev, was_lock;
    stat_t s;
    beat_t b;
    cand     = req_v_i & en_mask_i;
    was_lock = m_lock;
    win      = -1;
    if (m_lock) begin
      ev  = req_v_i[m_owner];
      idx = m_owner;
    end else begin
      for (int i = 0; i < N; i++)
        if (win < 0 && cand[(m_ptr + i) % N]) win = (m_ptr + i) % N;
      ev  = (win >= 0);
      idx = ev ? win : m_owner;
    end
    s.v    = ev;
    s.dat  = bt[idx];
    s.own  = idx;
    s.yumi = (ev && ready_i) ? N'(1 << idx) : '0;
    s.busy = m_lock;
    s.pkt  = m_pkt;
    s.err  = m_err;
    sq.push_back(s);

    if (!was_lock) m_stall = 0;
    else if (req_v_i[m_owner]) m_stall = 0;
    else begin
      m_stall++;
      if (m_stall >= 255) m_err = 1;
    end

    if (ev && ready_i) begin
      b.own = idx;
      b.dat = bt[idx];
      bq.push_back(b);
      m_owner = idx;
      if (rem[idx] == 1) begin
        m_lock = 0;
        m_ptr  = (idx + 1) % N;
        if (m_pkt < 65535) m_pkt++;
      end else begin
        m_lock = 1;
      end
      rem[idx]--;
      if (rem[idx] > 0) bt[idx] = rand_beat();
    end
  endtask

  task automatic step(input int pv, input int pr, input logic [N-1:0] mask, input logic [N-1:0] hold_off);
    logic [N-1:0] v;
    @(posedge clk_i); #1;
    for (int k = 0; k < N; k++) begin
      if (rem[k] == 0 && gen_max > 0) new_pkt(k, $urandom_range(1, gen_max));
      v[k] = (rem[k] > 0) && !hold_off[k] && ($urandom_range(0, 99) < pv);
      req_data_i[k*W +: W] = bt[k];
      req_last_i[k]        = (rem[k] == 1);
    end
    req_v_i   = v;
    en_mask_i = mask;
    ready_i   = ($urandom_range(0, 99) < pr);
    model_eval();
  endtask

  task automatic drain();
    bit done;
    gen_max = 0;
    done    = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      done = !m_lock;
      for (int k = 0; k < N; k++) if (rem[k] != 0) done = 0;
      if (!done) step(100, 100, 4'hF, 4'h0);
    end
    check("drain_timeout", done, 1'b1);
  endtask

  // Monitor: compares every cycle's status and pops a beat whenever the link transfers.
  initial begin
    stat_t s;
    beat_t b;
    forever begin
      @(negedge clk_i);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("v_o", v_o, s.v);
        if (s.v) check("data_o", data_o, s.dat);
        check("owner_o", owner_o, s.own);
        check("req_yumi_o", req_yumi_o, s.yumi);
        check("busy_o", busy_o, s.busy);
        check("pkt_cnt_o", pkt_cnt_o, s.pkt);
        check("stall_err_o", stall_err_o, s.err);
      end
      if (v_o && ready_i) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected owner=%0d data=%0h expected none", owner_o, data_o);
        end else begin
          b = bq.pop_front();
          check("beat_owner", owner_o, b.own);
          check("beat_data", data_o, b.dat);
        end
      end
    end
  end

  initial begin
    async_reset_n_i = 1'b0;
    en_mask_i  = '1;
    req_v_i    = '0;
    req_data_i = '0;
    req_last_i = '0;
    ready_i    = 1'b0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; bt[k] = rand_beat(); end
    model_reset();
    #1;
    check("rst_v_o", v_o, 1'b0);
    check("rst_yumi", req_yumi_o, 4'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_owner", owner_o, 2'd0);
    check("rst_pkt_cnt", pkt_cnt_o, 16'd0);
    check("rst_stall_err", stall_err_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 async_reset_n_i = 1'b1;

    // Single-beat packets from everyone: owners rotate 0,1,2,3,0.
    gen_max = 1;
    repeat (5) step(100, 100, 4'hF, 4'h0);

    // Lock hold: 3-beat packet from req1 while req2 waits.
    gen_max = 0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    new_pkt(1, 3);
    new_pkt(2, 1);
    repeat (5) step(100, 100, 4'hF, 4'h0);

    // Backpressure mid-packet.
    new_pkt(3, 5);
    repeat (2) step(100, 100, 4'hF, 4'h0);
    repeat (4) step(100, 0, 4'hF, 4'h0);
    drain();

    // Mask: requester 2 blocked; then clear bit 1 under a req1 lock.
    gen_max = 3;
    repeat (60) step(90, 80, 4'b1011, 4'h0);
    drain();
    new_pkt(1, 3);
    step(100, 100, 4'hF, 4'h0);
    new_pkt(3, 2);
    repeat (4) step(100, 100, 4'b1001, 4'h0);
    drain();

    // Stall: req0 locked, then silent for 260 cycles.
    new_pkt(0, 2);
    step(100, 100, 4'hF, 4'h0);
    new_pkt(1, 1);
    repeat (260) step(100, 100, 4'hF, 4'b0001);
    drain();

    // Random traffic.
    gen_max = 4;
    repeat (2000) step(70, 70, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 4'h0);
    drain();

    // Asynchronous reset during beat 2 of a 4-beat packet.
    new_pkt(1, 4);
    step(100, 100, 4'hF, 4'h0);
    @(posedge clk_i); #1;
    for (int k = 0; k < N; k++) if (k != 1) new_pkt(k, 1);
    for (int k = 0; k < N; k++) req_data_i[k*W +: W] = bt[k];
    req_v_i = 4'hF;
    ready_i = 1'b1;
    en_mask_i = 4'hF;
    async_reset_n_i = 1'b0;
    #1;
    check("midrst_v_o", v_o, 1'b0);
    check("midrst_yumi", req_yumi_o, 4'h0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_owner", owner_o, 2'd0);
    check("midrst_pkt_cnt", pkt_cnt_o, 16'd0);
    check("midrst_stall_err", stall_err_o, 1'b0);
    model_reset();
    for (int k = 0; k < N; k++) rem[k] = 0;
    repeat (2) @(posedge clk_i);
    #1;
    req_v_i = '0;
    ready_i = 1'b0;
    async_reset_n_i = 1'b1;
    gen_max = 1;
    repeat (4) step(100, 100, 4'hF, 4'h0);
    drain();

    @(negedge clk_i); #1;
    check("status_queue_empty", sq.size(), 0);
    check("beat_queue_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
